// File: rtl/i2s_tx_sched.sv
// rtl/i2s_tx_sched.sv - I2S transmit frame scheduler with two-requester stereo FIFO
//
// Purpose: merges stereo frames from two requesters (round-robin) into a small
// FIFO and presents one frame per I2S frame to the transmitter. A PRIME/RUN
// state machine waits for PRIME_LVL frames before streaming. In RUN it reports
// underruns and falls back to PRIME. Every register updates on negedge sclk.
//
// Ports:
//   sclk                 clock (all state changes on its falling edge)
//   rst                  synchronous active-high reset
//   ws_in                word select from the transmitter
//   req0_valid/left/right/ready  requester 0 (DSP path) frame handshake
//   req1_valid/left/right/ready  requester 1 (test-tone path) frame handshake
//   mute                 load silence at the next frame boundary
//   left_chan/right_chan frame presented to the transmitter
//   underrun             one-cycle pulse: frame load found FIFO empty in RUN
//   level                FIFO occupancy
//   running              high while in RUN
//
// Option: define I2S_TX_SCHED_HOLD_EN to re-present the last loaded frame on
// an underrun instead of silence.

module i2s_tx_sched #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 4,
  parameter int PRIME_LVL = 2
) (
  input  logic                     sclk,
  input  logic                     rst,
  input  logic                     ws_in,
  input  logic                     req0_valid,
  input  logic [WIDTH-1:0]         req0_left,
  input  logic [WIDTH-1:0]         req0_right,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [WIDTH-1:0]         req1_left,
  input  logic [WIDTH-1:0]         req1_right,
  output logic                     req1_ready,
  input  logic                     mute,
  output logic [WIDTH-1:0]         left_chan,
  output logic [WIDTH-1:0]         right_chan,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     running
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {PRIME, RUN} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] mem_l [DEPTH];
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level_nxt;
  logic             full_q;
  logic             ws_q;
  logic             prio;       // 0: requester 0 wins a tie, 1: requester 1 wins
  logic             boundary;
  logic             grant0, grant1;
  logic             push, pop;
  logic             ur_nxt;
  logic [WIDTH-1:0] wdata_l, wdata_r;
  logic [WIDTH-1:0] load_l, load_r;

  // Left-channel start: ws_in fell since the previous cycle. ws_q is cleared
  // in reset so the first cycle after release can never see a boundary.
  assign boundary = ws_q & ~ws_in;

  assign grant0 = req0_valid & (~req1_valid | ~prio);
  assign grant1 = req1_valid & (~req0_valid | prio);

  // Full is taken from the registered flag, so a same-cycle pop never frees
  // a slot for a write.
  assign req0_ready = grant0 & ~full_q & ~rst;
  assign req1_ready = grant1 & ~full_q & ~rst;

  assign push    = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign wdata_l = req1_ready ? req1_left  : req0_left;
  assign wdata_r = req1_ready ? req1_right : req0_right;

  assign running = (state == RUN);

  // Occupancy decisions use the registered level, so a push landing in the
  // boundary cycle does not rescue an empty FIFO.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    ur_nxt    = 1'b0;
    load_l    = '0;
    load_r    = '0;
    if (boundary) begin
      if (state == PRIME) begin
        if (level >= LW'(PRIME_LVL)) begin
          pop       = 1'b1;
          load_l    = mem_l[rd_ptr];
          load_r    = mem_r[rd_ptr];
          state_nxt = RUN;
        end
      end else begin
        if (level != '0) begin
          pop    = 1'b1;
          load_l = mem_l[rd_ptr];
          load_r = mem_r[rd_ptr];
        end else begin
          ur_nxt    = 1'b1;
          state_nxt = PRIME;
`ifdef I2S_TX_SCHED_HOLD_EN
          load_l    = left_chan;
          load_r    = right_chan;
`endif
        end
      end
      // Mute only affects what is shown; pop and state move as usual.
      if (mute) begin
        load_l = '0;
        load_r = '0;
      end
    end
  end

  assign level_nxt = level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_ff @(negedge sclk) begin
    if (rst) begin
      state <= PRIME;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(negedge sclk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      full_q     <= 1'b0;
      ws_q       <= 1'b0;
      prio       <= 1'b0;
      left_chan  <= '0;
      right_chan <= '0;
      underrun   <= 1'b0;
    end else begin
      ws_q     <= ws_in;
      underrun <= ur_nxt;
      level    <= level_nxt;
      full_q   <= (level_nxt == LW'(DEPTH));
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        // The requester just served loses the next tie.
        prio   <= req0_ready;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (boundary) begin
        left_chan  <= load_l;
        right_chan <= load_r;
      end
    end
  end

  always_ff @(negedge sclk) begin
    if (push) begin
      mem_l[wr_ptr] <= wdata_l;
      mem_r[wr_ptr] <= wdata_r;
    end
  end

endmodule

// File: tb/tb_i2s_tx_sched.sv
// tb/tb_i2s_tx_sched.sv - self-checking bench for i2s_tx_sched against a queue model

module tb_i2s_tx_sched;

  localparam int WIDTH     = 16;
  localparam int DEPTH     = 4;
  localparam int PRIME_LVL = 2;
  localparam int LW        = $clog2(DEPTH) + 1;
  localparam int VW        = 2 * WIDTH + LW + 4;

  logic             sclk = 1'b0;
  logic             rst = 1'b1;
  logic             ws_in = 1'b0;
  logic             req0_valid = 1'b0;
  logic [WIDTH-1:0] req0_left = '0;
  logic [WIDTH-1:0] req0_right = '0;
  logic             req0_ready;
  logic             req1_valid = 1'b0;
  logic [WIDTH-1:0] req1_left = '0;
  logic [WIDTH-1:0] req1_right = '0;
  logic             req1_ready;
  logic             mute = 1'b0;
  logic [WIDTH-1:0] left_chan;
  logic [WIDTH-1:0] right_chan;
  logic             underrun;
  logic [LW-1:0]    level;
  logic             running;

  i2s_tx_sched #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PRIME_LVL(PRIME_LVL)) dut (
    .sclk       (sclk),
    .rst        (rst),
    .ws_in      (ws_in),
    .req0_valid (req0_valid),
    .req0_left  (req0_left),
    .req0_right (req0_right),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_left  (req1_left),
    .req1_right (req1_right),
    .req1_ready (req1_ready),
    .mute       (mute),
    .left_chan  (left_chan),
    .right_chan (right_chan),
    .underrun   (underrun),
    .level      (level),
    .running    (running)
  );

  always #5 sclk = ~sclk;

  // Reference model: frames in a queue, a running flag, a tie-break owner.
  logic [2*WIDTH-1:0] m_q[$];
  bit               m_run, m_prio, m_ws_q, m_underrun;
  logic [WIDTH-1:0] m_left, m_right;
  bit               e_r0, e_r1, o_r0, o_r1;
  int               o_lvl_pre;
  bit               auto_ws;
  int               ws_half, ws_cnt;
  int               total, bad;

  function automatic void model_ready();
    bit full;
    full = (m_q.size() == DEPTH);
    e_r0 = !rst && !full && req0_valid && (!req1_valid || !m_prio);
    e_r1 = !rst && !full && req1_valid && (!req0_valid || m_prio);
  endfunction

  task automatic model_update();
    logic [2*WIDTH-1:0] f;
    logic [WIDTH-1:0]   nl, nr;
    int                 lvl;
    if (rst) begin
      m_q.delete();
      m_run = 0; m_prio = 0; m_ws_q = 0; m_underrun = 0;
      m_left = '0; m_right = '0;
      return;
    end
    lvl = m_q.size();
    m_underrun = 0;
    if (!ws_in && m_ws_q) begin
      nl = '0; nr = '0;
      if (!m_run) begin
        if (lvl >= PRIME_LVL) begin
          f = m_q.pop_front(); {nl, nr} = f; m_run = 1;
        end
      end else if (lvl > 0) begin
        f = m_q.pop_front(); {nl, nr} = f;
      end else begin
        m_underrun = 1; m_run = 0;
`ifdef I2S_TX_SCHED_HOLD_EN
        nl = m_left; nr = m_right;
`endif
      end
      if (mute) begin nl = '0; nr = '0; end
      m_left = nl; m_right = nr;
    end
    if (e_r0) begin m_q.push_back({req0_left, req0_right}); m_prio = 1; end
    if (e_r1) begin m_q.push_back({req1_left, req1_right}); m_prio = 0; end
    m_ws_q = ws_in;
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {left_chan, right_chan, level, running, underrun, o_r0, o_r1};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_left, m_right, LW'(m_q.size()), m_run, m_underrun, e_r0, e_r1};
  endfunction

  // One sclk period: sample readies before the falling edge, advance DUT and
  // model on it, then sample registered outputs half a period later.
  task automatic tick();
    #1;
    model_ready();
    o_r0 = req0_ready; o_r1 = req1_ready; o_lvl_pre = int'(level);
    @(negedge sclk);
    model_update();
    @(posedge sclk);
    #1;
    if (auto_ws) begin
      ws_cnt++;
      if (ws_cnt >= ws_half) begin ws_cnt = 0; ws_in = ~ws_in; end
    end
  endtask

  task automatic do_reset();
    auto_ws = 0; ws_in = 0; ws_cnt = 0; mute = 0;
    req0_valid = 0; req1_valid = 0;
    rst = 1;
    repeat (2) tick();
    rst = 0;
  endtask

  task automatic test_reset();
    auto_ws = 0; ws_in = 1; rst = 1; mute = 0;
    req0_valid = 1; req1_valid = 1;
    req0_left = 16'h1234; req0_right = 16'h5678;
    repeat (3) tick();
    total++;
    if (o_r0 !== 1'b0 || o_r1 !== 1'b0) begin
      bad++; $display("FAIL reset_ready got=%b%b exp=00", o_r0, o_r1);
    end
    total++;
    if ({left_chan, right_chan, level, running, underrun} !== '0) begin
      bad++; $display("FAIL reset_state got=%h exp=0", {left_chan, right_chan, level, running, underrun});
    end
    total++;
    if (dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_model got=%h exp=%h", dut_vec(), exp_vec());
    end
    req0_valid = 0; req1_valid = 0; ws_in = 0; rst = 0;
  endtask

  task automatic push0(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r, input string nm);
    int n;
    req0_valid = 1; req0_left = l; req0_right = r;
    n = 0;
    do begin
      tick(); n++;
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL %s_model got=%h exp=%h", nm, dut_vec(), exp_vec());
      end
    end while (!o_r0 && n < 10);
    total++;
    if (!o_r0) begin bad++; $display("FAIL %s_push_timeout got=0 exp=1", nm); end
    req0_valid = 0;
  endtask

  task automatic test_basic();
    int n, ur_cnt;
    do_reset(); auto_ws = 1; ws_half = 16; ws_cnt = 0;
    push0(16'h1111, 16'h2222, "basic");
    push0(16'h3333, 16'h4444, "basic");
    n = 0;
    while (running !== 1'b1 && n < 100) begin
      tick(); n++;
      total++;
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL basic_model got=%h exp=%h", dut_vec(), exp_vec()); end
    end
    total++;
    if (running !== 1'b1 || left_chan !== 16'h1111 || right_chan !== 16'h2222) begin
      bad++; $display("FAIL basic_first got=%b/%h/%h exp=1/1111/2222", running, left_chan, right_chan);
    end
    n = 0;
    while (left_chan === 16'h1111 && n < 40) begin
      tick(); n++;
      total++;
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL basic_model got=%h exp=%h", dut_vec(), exp_vec()); end
    end
    total++;
    if (running !== 1'b1 || left_chan !== 16'h3333 || right_chan !== 16'h4444) begin
      bad++; $display("FAIL basic_second got=%b/%h/%h exp=1/3333/4444", running, left_chan, right_chan);
    end
    n = 0;
    while (running === 1'b1 && n < 40) begin
      tick(); n++;
      total++;
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL underrun_model got=%h exp=%h", dut_vec(), exp_vec()); end
    end
    ur_cnt = int'(underrun);
    total++;
    if (running !== 1'b0) begin bad++; $display("FAIL underrun_running got=%b exp=0", running); end
`ifdef I2S_TX_SCHED_HOLD_EN
    total++;
    if (left_chan !== 16'h3333 || right_chan !== 16'h4444) begin
      bad++; $display("FAIL underrun_out got=%h/%h exp=3333/4444", left_chan, right_chan);
    end
`else
    total++;
    if (left_chan !== 16'h0 || right_chan !== 16'h0) begin
      bad++; $display("FAIL underrun_out got=%h/%h exp=0/0", left_chan, right_chan);
    end
`endif
    repeat (5) begin
      tick();
      ur_cnt += int'(underrun);
    end
    total++;
    if (ur_cnt != 1) begin bad++; $display("FAIL underrun_pulse got=%0d exp=1", ur_cnt); end
  endtask

  task automatic test_arbiter();
    int last, who, full_seen;
    do_reset(); auto_ws = 1; ws_half = 3; ws_cnt = 0;
    req0_valid = 1; req1_valid = 1;
    last = -1; full_seen = 0;
    for (int i = 0; i < 60; i++) begin
      req0_left = 16'($urandom); req0_right = 16'($urandom);
      req1_left = 16'($urandom); req1_right = 16'($urandom);
      tick();
      total++;
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL arb_model cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec()); end
      if (o_lvl_pre == DEPTH) begin
        full_seen++;
        total++;
        if (o_r0 || o_r1) begin bad++; $display("FAIL arb_full_ready got=%b%b exp=00", o_r0, o_r1); end
      end
      if (o_r0 || o_r1) begin
        who = o_r1 ? 1 : 0;
        total++;
        if (last < 0) begin
          if (who != 0) begin bad++; $display("FAIL arb_first got=%0d exp=0", who); end
        end else if (who == last) begin
          bad++; $display("FAIL arb_alternate got=%0d exp=%0d", who, 1 - last);
        end
        last = who;
      end
    end
    total++;
    if (full_seen == 0) begin bad++; $display("FAIL arb_reach_full got=0 exp>0"); end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_mute();
    int n;
    do_reset(); auto_ws = 1; ws_half = 16; ws_cnt = 0;
    mute = 1;
    push0(16'h5555, 16'h6666, "mute");
    push0(16'h7777, 16'h8888, "mute");
    n = 0;
    while (running !== 1'b1 && n < 100) begin
      tick(); n++;
      total++;
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL mute_model got=%h exp=%h", dut_vec(), exp_vec()); end
    end
    total++;
    if (left_chan !== 16'h0 || right_chan !== 16'h0 || level !== LW'(1) || running !== 1'b1) begin
      bad++; $display("FAIL mute_load got=%h/%h/%0d exp=0/0/1", left_chan, right_chan, level);
    end
    mute = 0;
    n = 0;
    while (left_chan === 16'h0 && n < 40) begin
      tick(); n++;
      total++;
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL mute_model got=%h exp=%h", dut_vec(), exp_vec()); end
    end
    total++;
    if (left_chan !== 16'h7777 || right_chan !== 16'h8888) begin
      bad++; $display("FAIL mute_after got=%h/%h exp=7777/8888", left_chan, right_chan);
    end
  endtask

  task automatic test_reset_mid();
    int leak;
    do_reset(); auto_ws = 1; ws_half = 16; ws_cnt = 0;
    push0(16'hA001, 16'hB001, "rstmid");
    push0(16'hA002, 16'hB002, "rstmid");
    push0(16'hA003, 16'hB003, "rstmid");
    total++;
    if (level !== LW'(3)) begin bad++; $display("FAIL rstmid_level3 got=%0d exp=3", level); end
    repeat (3) tick();
    rst = 1; req0_valid = 1; req0_left = 16'hA004; req0_right = 16'hB004;
    tick();
    rst = 0; req0_valid = 0;
    total++;
    if (level !== '0 || left_chan !== '0 || right_chan !== '0 || running !== 1'b0) begin
      bad++; $display("FAIL rstmid_clear got=%0d/%h/%h/%b exp=0/0/0/0", level, left_chan, right_chan, running);
    end
    push0(16'hC001, 16'hD001, "rstmid");
    push0(16'hC002, 16'hD002, "rstmid");
    leak = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (left_chan[15:12] == 4'hA || right_chan[15:12] == 4'hB) leak++;
      total++;
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL rstmid_model cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec()); end
    end
    total++;
    if (leak != 0) begin bad++; $display("FAIL rstmid_leak got=%0d exp=0", leak); end
  endtask

  task automatic test_random();
    do_reset(); auto_ws = 1; ws_half = 4; ws_cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 150 == 0) ws_half = int'($urandom_range(1, 8));
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 2) == 0);
      req0_left = 16'($urandom); req0_right = 16'($urandom);
      req1_left = 16'($urandom); req1_right = 16'($urandom);
      mute = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL rand_model cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    rst = 0; req0_valid = 0; req1_valid = 0; mute = 0;
  endtask

  initial begin
    total = 0; bad = 0;
    auto_ws = 0; ws_half = 16; ws_cnt = 0;
    test_reset();
    test_basic();
    test_arbiter();
    test_mute();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_tx_sched.md
I2S_TX_SCHED -- requirements
Module: i2s_tx_sched

Interface
REQ-001 Parameter WIDTH, default 16: bits per channel sample.
REQ-002 Parameter DEPTH, default 4: stereo-frame FIFO entries; power of two, at least 2.
REQ-003 Parameter PRIME_LVL, default 2: FIFO level needed to leave PRIME; range 1..DEPTH.
REQ-004 sclk  in  1  sole clock; all logic updates on negedge sclk, matching the I2S transmitter.
REQ-005 rst  in  1  reset; synchronous and active-high.
REQ-006 ws_in  in  1  word select driven by the transmitter.
REQ-007 req0_valid  in  1  requester 0 (DSP path) offers a frame.
REQ-008 req0_left, req0_right  in  WIDTH each  requester 0 frame data.
REQ-009 req0_ready  out  1  requester 0 frame accepted this cycle.
REQ-010 req1_valid, req1_left, req1_right, req1_ready: same as REQ-007..009, for requester 1 (test-tone path).
REQ-011 mute  in  1  force silence at the next frame load.
REQ-012 left_chan, right_chan  out  WIDTH each  frame presented to the transmitter.
REQ-013 underrun  out  1  one-cycle pulse when a frame load finds the FIFO empty in RUN.
REQ-014 level  out  $clog2(DEPTH)+1  FIFO occupancy.
REQ-015 running  out  1  high while the state machine is in RUN.

Function
REQ-016 A frame boundary is detected when ws_in is 0 and its value registered one cycle earlier is 1 (left-channel start); exactly one boundary is detected per ws_in falling edge.
REQ-017 Arbiter: round-robin, at most one FIFO write per cycle.
- When both requesters are valid, the one not most recently accepted is granted.
- When only one is valid, that one is granted.
- The round-robin pointer changes only on an accepted write.
REQ-018 reqN_ready is combinational: (grant to N) AND (registered full flag is 0). A write occurs when reqN_valid AND reqN_ready.
REQ-019 When the FIFO is full, no write is accepted, even if a pop occurs in the same cycle.
REQ-020 On a simultaneous push and pop with the FIFO non-empty, level is unchanged and data order is preserved (FIFO). Pointers wrap modulo DEPTH.
REQ-021 The state machine has two states, PRIME and RUN.
- PRIME: at a boundary, if level >= PRIME_LVL, pop the head, load it, and go to RUN; otherwise load silence, do not pop, and stay in PRIME.
- RUN: at a boundary, if level > 0, pop the head and load it; otherwise pulse underrun for one cycle, go to PRIME, and load per REQ-029/030.
REQ-022 A boundary coinciding with a push into an empty FIFO counts as empty: underrun in RUN, no pop; the pushed frame is retained.
REQ-023 left_chan and right_chan update only in the cycle after a boundary (one-cycle latency) and hold stable for the rest of the frame.
REQ-024 If mute is 1 at a boundary, both outputs load 0. The pop and state transitions still occur as if mute were 0.
REQ-025 Silence is all-zero samples.

Reset
REQ-026 While rst is 1 at a negedge sclk:
- state = PRIME, FIFO emptied, level = 0;
- left_chan and right_chan = 0; underrun = 0; running = 0;
- round-robin pointer favours requester 0; registered ws_in = 0.
REQ-027 While rst is 1, req0_ready and req1_ready are 0.
REQ-028 Reset asserted mid-frame or mid-write discards all FIFO contents. No boundary is detected in the first cycle after reset release.

Configuration
REQ-029 With macro I2S_TX_SCHED_HOLD_EN defined, an underrun load in RUN re-presents the last loaded frame (subject to mute). Loads made while already in PRIME still output silence.
REQ-030 Without I2S_TX_SCHED_HOLD_EN, an underrun load in RUN outputs silence.

Verification
REQ-031 Reset, then req0 pushes (0x1111,0x2222),(0x3333,0x4444) with ws_in toggling every 16 cycles: first boundary after level>=2 gives left_chan=0x1111, right_chan=0x2222 and running=1; next boundary gives 0x3333/0x4444.
REQ-032 Both requesters valid every cycle, FIFO draining: accepted writes alternate req0, req1, req0, ...; each ready is low when FIFO is full (level=4).
REQ-033 FIFO drained in RUN, then a boundary occurs: underrun pulses for exactly 1 cycle; running=0; outputs = 0 without the macro, or the prior frame 0x3333/0x4444 with I2S_TX_SCHED_HOLD_EN.
REQ-034 mute=1 with FIFO holding (0x5555,0x6666): outputs = 0 and level decrements by 1; after mute=0, the next frame is unaffected.
REQ-035 rst asserted mid-frame with level=3: level=0, outputs=0, state=PRIME next cycle; pre-reset frames never appear at the outputs.
